row_accumulator: RTL and testbench

Streaming, parametrised successor to the three-element row adder. It accumulates a variable-length group of FEAT-wide feature rows, one row per accepted beat, into a single sum row. The group boundary is marked by `in_last`. It sits between the neighbour-row fetch stage and the GNN aggregation/normalisation stage, and reports the group's row count (node degree) and an overflow flag with each result.

---
 rtl/row_acc_pkg.sv | 17 +
 rtl/row_add_sat.sv | 18 +
 rtl/row_accumulator.sv | 120 ++++++++++++
 tb/tb_row_accumulator.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_acc_pkg.sv
// Shared types and defaults for the streaming row accumulator and its element adder.
package row_acc_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FEAT_DEF  = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Row shape at the default geometry; parameterised instances declare their own arrays.
  typedef logic [WIDTH_DEF-1:0] row_t [0:FEAT_DEF-1];

endpackage

// File: rtl/row_add_sat.sv
// One feature element adder: WIDTH-bit unsigned add with wrap or clamp on carry-out.
module row_add_sat #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[WIDTH];
  assign sum  = ((SATURATE != 0) && full[WIDTH]) ? '1 : full[WIDTH-1:0];

endmodule

// File: rtl/row_accumulator.sv
// Sums a variable-length group of feature rows (terminated by in_last) into one result row
// with the group's row count and a sticky overflow flag.
module row_accumulator
  import row_acc_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int FEAT     = FEAT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_row [0:FEAT-1],
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_row [0:FEAT-1],
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  // valid/ready: a beat moves on a rising edge where valid and ready are both high;
  // a producer holds valid and data stable until that edge, ready never depends on valid.

  state_t           state;
  logic             first;
  logic [WIDTH-1:0] acc      [0:FEAT-1];
  logic [WIDTH-1:0] op_a     [0:FEAT-1];
  logic [WIDTH-1:0] sum      [0:FEAT-1];
  logic [FEAT-1:0]  elem_ovf;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf;
  logic             ovf_next;
  logic             accept;

  assign accept = in_valid && in_ready;

  // Zeroing the accumulator operand on the first beat makes the add a plain load.
  for (genvar gi = 0; gi < FEAT; gi++) begin : g_elem
    assign op_a[gi] = first ? '0 : acc[gi];

    row_add_sat #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_add (
      .a   (op_a[gi]),
      .b   (in_row[gi]),
      .sum (sum[gi]),
      .ovf (elem_ovf[gi])
    );
  end

  always_comb begin
    cnt_next = cnt;
    ovf_next = ovf;
    if (first) begin
      cnt_next = CNT_W'(1);
      ovf_next = 1'b0;
    end else begin
      cnt_next = (&cnt) ? cnt : cnt + 1'b1;
      ovf_next = ovf | (|elem_ovf);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      first     <= 1'b1;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      for (int i = 0; i < FEAT; i++) begin
        acc[i]     <= '0;
        out_row[i] <= '0;
      end
    end else begin
      case (state)
        INIT: begin
          state    <= ACC;
          in_ready <= 1'b1;
        end
        ACC: begin
          if (accept) begin
            for (int i = 0; i < FEAT; i++) acc[i] <= sum[i];
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            first <= in_last;
            if (in_last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_count <= cnt_next;
              out_ovf   <= ovf_next;
              for (int i = 0; i < FEAT; i++) out_row[i] <= sum[i];
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= INIT;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_row_accumulator.sv
// Bench for row_accumulator: wrap, clamp and narrow-counter instances share one input
// stream; a reference model fills an expected queue that is drained on each output handshake.
module tb_row_accumulator;
  import row_acc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic in_valid  = 1'b0;
  logic in_last   = 1'b0;
  logic out_ready = 1'b1;
  row_t in_row;

  row_t        row_w, row_c, row_s;
  logic [7:0]  cnt_w, cnt_c;
  logic [1:0]  cnt_s;
  logic        ovf_w, ovf_c, ovf_s;
  logic        ir_w, ir_c, ir_s;
  logic        ov_w, ov_c, ov_s;

  row_accumulator #(.WIDTH(16), .FEAT(3), .CNT_W(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .in_row(in_row),
    .in_last(in_last), .out_valid(ov_w), .out_ready(out_ready), .out_row(row_w),
    .out_count(cnt_w), .out_ovf(ovf_w));

  row_accumulator #(.WIDTH(16), .FEAT(3), .CNT_W(8), .SATURATE(1)) u_clamp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_c), .in_row(in_row),
    .in_last(in_last), .out_valid(ov_c), .out_ready(out_ready), .out_row(row_c),
    .out_count(cnt_c), .out_ovf(ovf_c));

  row_accumulator #(.WIDTH(16), .FEAT(3), .CNT_W(2), .SATURATE(0)) u_cnt2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .in_row(in_row),
    .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready), .out_row(row_s),
    .out_count(cnt_s), .out_ovf(ovf_s));

  logic [63:0] obs [3];
  logic        ov  [3];
  logic        ir  [3];
  assign obs[0] = {7'b0, ovf_w, cnt_w, row_w[2], row_w[1], row_w[0]};
  assign obs[1] = {7'b0, ovf_c, cnt_c, row_c[2], row_c[1], row_c[0]};
  assign obs[2] = {7'b0, ovf_s, 6'b0, cnt_s, row_s[2], row_s[1], row_s[0]};
  assign ov[0] = ov_w;
  assign ov[1] = ov_c;
  assign ov[2] = ov_s;
  assign ir[0] = ir_w;
  assign ir[1] = ir_c;
  assign ir[2] = ir_s;

  // ---------------- scoreboard state ----------------
  logic [191:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int timeouts = 0;
  int gap_max  = 0;
  logic finish_req = 1'b0;

  int          sat_cfg [3] = '{0, 1, 0};
  int unsigned cmax    [3] = '{255, 255, 3};
  int unsigned m_acc   [3][3];
  int unsigned m_cnt   [3];
  bit          m_ovf   [3];
  bit          m_first;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_beat();
    logic [191:0] e;
    int unsigned  s;
    bit           o;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        s = (m_first ? 0 : m_acc[k][i]) + int'(in_row[i]);
        o = (s > 65535);
        if (o) s = (sat_cfg[k] != 0) ? 65535 : s - 65536;
        m_acc[k][i] = s;
        if (!m_first && o) m_ovf[k] = 1'b1;
      end
      if (m_first) begin
        m_cnt[k] = 1;
        m_ovf[k] = 1'b0;
      end else if (m_cnt[k] < cmax[k]) begin
        m_cnt[k] = m_cnt[k] + 1;
      end
      e[k*64 +: 64] = {7'b0, m_ovf[k], 8'(m_cnt[k]), 16'(m_acc[k][2]), 16'(m_acc[k][1]),
                       16'(m_acc[k][0])};
    end
    if (in_last) exp_q.push_back(e);
    m_first = in_last;
  endtask

  // ---------------- monitor / checker ----------------
  initial begin : monitor
    bit last_prev = 1'b0;
    bit hs_prev   = 1'b0;
    int since_rel = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_first   = 1'b1;
        exp_q.delete();
        last_prev = 1'b0;
        hs_prev   = 1'b0;
        since_rel = 0;
        for (int k = 0; k < 3; k++) begin
          check("reset_row", obs[k], 64'd0);
          check("reset_flags", {62'd0, ov[k], ir[k]}, 64'd0);
        end
      end else begin
        if (since_rel < 10) since_rel++;
        for (int k = 0; k < 3; k++) begin
          if (since_rel == 1) check("init_ready", {63'd0, ir[k]}, 64'd0);
          if (since_rel == 2) check("acc_ready", {63'd0, ir[k]}, 64'd1);
          if (last_prev) check("valid_after_last", {62'd0, ov[k], ir[k]}, 64'd2);
          if (hs_prev) check("ready_after_hs", {62'd0, ov[k], ir[k]}, 64'd1);
          if (ov[k]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_out", {63'd0, ov[k]}, 64'd0);
            end else begin
              check("out_data", obs[k], exp_q[0][k*64 +: 64]);
              check("ready_in_out", {63'd0, ir[k]}, 64'd0);
            end
          end
        end
        last_prev = 1'b0;
        hs_prev   = 1'b0;
        if (in_valid && ir[0]) begin
          last_prev = in_last;
          model_beat();
        end
        if (ov[0] && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          hs_prev = 1'b1;
        end
        if (finish_req) begin
          check("timeouts", 64'(timeouts), 64'd0);
          check("queue_drained", 64'(exp_q.size()), 64'd0);
          $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
          $finish;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_row(input row_t r, input logic last);
    int budget = 0;
    repeat ($urandom_range(0, gap_max)) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) in_row[i] = 16'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_row   = r;
    in_last  = last;
    do begin
      @(negedge clk);
      budget++;
    end while (!ir_w && budget < 100);
    if (budget >= 100) timeouts++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic rand_group(input int n, input int maxv);
    row_t r;
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < 3; i++) r[i] = 16'($urandom_range(0, maxv));
      send_row(r, j == n - 1);
    end
  endtask

  task automatic wait_idle();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((ov_w || !ir_w) && budget < 100);
    if (budget >= 100) timeouts++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid();
    int budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!ov_w && budget < 100);
    if (budget >= 100) timeouts++;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    for (int i = 0; i < 3; i++) in_row[i] = '0;
    do_reset();

    send_row('{16'd1, 16'd2, 16'd3}, 1'b0);
    send_row('{16'd10, 16'd20, 16'd30}, 1'b0);
    send_row('{16'd100, 16'd200, 16'd300}, 1'b1);
    wait_idle();

    send_row('{16'hFFF0, 16'd5, 16'd0}, 1'b0);
    send_row('{16'h0020, 16'd5, 16'd0}, 1'b1);
    wait_idle();

    send_row('{16'd7, 16'd8, 16'd9}, 1'b1);
    wait_idle();

    for (int j = 0; j < 5; j++) send_row('{16'd1, 16'd1, 16'd1}, j == 4);
    wait_idle();

    gap_max   = 2;
    out_ready = 1'b0;
    rand_group(5, 65535);
    wait_out_valid();
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    gap_max = 0;
    send_row('{16'd4, 16'd5, 16'd6}, 1'b1);
    wait_idle();

    gap_max = 1;
    for (int g = 0; g < 6; g++) begin
      rand_group($urandom_range(1, 6), (g % 2 == 0) ? 1000 : 65535);
      wait_idle();
    end

    gap_max = 0;
    send_row('{16'd9, 16'd9, 16'd9}, 1'b0);
    send_row('{16'd9, 16'd9, 16'd9}, 1'b0);
    do_reset();
    send_row('{16'd4, 16'd4, 16'd4}, 1'b1);
    wait_idle();

    finish_req = 1'b1;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
